vga_pixel_addr_gen: RTL and testbench

Parametrised frame-buffer address generator for the VGA path.
- Converts the timing generator's hCounter/vCounter into a linear read address for the pixel memory.
- Supports configurable active area, base address and integer pixel replication (2^SCALE_LOG2).
- Uses a registered row-base accumulator instead of a multiplier, and adds valid/line/frame strobes.
- Sits between the VGA timing counters and the frame-buffer RAM read port.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_row_base_acc.sv | 38 +++
 rtl/vga_pixel_addr_gen.sv | 119 +++++++++++
 tb/tb_vga_pixel_addr_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and frame sizing helper for the pixel address path.
package vga_pkg;

   localparam int unsigned H_ACTIVE_640 = 640;
   localparam int unsigned V_ACTIVE_480 = 480;
   localparam int unsigned CNT_W        = 10;

   // Number of source words in one frame after pixel replication is undone.
   function automatic longint unsigned frame_words(input longint unsigned h,
                                                   input longint unsigned v,
                                                   input int unsigned     s);
      return (h >> s) * (v >> s);
   endfunction

endpackage

// File: rtl/vga_row_base_acc.sv
// Row-base accumulator: load / add-step / hold register with a bypass of the
// value being written so consumers see the new base in the same cycle.
module vga_row_base_acc #(
   parameter int unsigned       ADDR_W  = 19,
   parameter logic [ADDR_W-1:0] RST_VAL = '0,
   parameter logic [ADDR_W-1:0] STEP    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_val,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_row_base_nxt
);

   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] w_next;

   always_comb begin
      w_next = r_row_base;
      if (i_load) begin
         w_next = i_load_val;
      end else if (i_inc) begin
         w_next = r_row_base + STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_base <= RST_VAL;
      end else begin
         r_row_base <= w_next;
      end
   end

   assign o_row_base_nxt = w_next;

endmodule

// File: rtl/vga_pixel_addr_gen.sv
// Frame-buffer read address generator driven by VGA h/v counters.
// Optional double buffering is enabled with `define VGA_DOUBLE_BUFFER_EN.
module vga_pixel_addr_gen
   import vga_pkg::*;
#(
   parameter int unsigned     H_ACTIVE   = H_ACTIVE_640,
   parameter int unsigned     V_ACTIVE   = V_ACTIVE_480,
   parameter int unsigned     ADDR_W     = 19,
   parameter int unsigned     SCALE_LOG2 = 0,
   parameter longint unsigned BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  hCounter,
   input  logic [CNT_W-1:0]  vCounter,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   output logic              line_start,
   output logic              frame_start
`ifdef VGA_DOUBLE_BUFFER_EN
   ,
   input  logic              buf_sel,
   output logic              buf_active
`endif
);

   localparam longint unsigned   FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE, SCALE_LOG2);
   localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LINE_WORDS  = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
   localparam logic [CNT_W-1:0]  H_ACT_C     = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0]  V_ACT_C     = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0]  V_MASK      = CNT_W'((32'd1 << SCALE_LOG2) - 32'd1);

   if (BASE_ADDR + FRAME_WORDS > (64'd1 << ADDR_W)) begin : g_size_chk
      $error("vga_pixel_addr_gen: frame does not fit in ADDR_W address space");
   end

   logic              r_synced;
   logic [ADDR_W-1:0] r_addr;
   logic              r_valid;
   logic              r_line_start;
   logic              r_frame_start;

   logic              w_at00;
   logic              w_line0;
   logic              w_act;
   logic              w_sync_ok;
   logic              w_inc;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] w_rb;
   logic [ADDR_W-1:0] w_hoff;

   assign w_at00    = (hCounter == '0) && (vCounter == '0);
   assign w_line0   = (hCounter == '0) && (vCounter < V_ACT_C);
   assign w_act     = (hCounter < H_ACT_C) && (vCounter < V_ACT_C);
   assign w_sync_ok = r_synced || w_at00;
   // Replicated lines (non-zero low bits of vCounter) reuse the previous source row.
   assign w_inc     = w_line0 && (vCounter != '0) && ((vCounter & V_MASK) == '0);
   assign w_hoff    = ADDR_W'(hCounter >> SCALE_LOG2);

`ifdef VGA_DOUBLE_BUFFER_EN
   logic r_buf_active;
   logic w_buf_nxt;

   // The buffer choice taken at (0,0) already steers that cycle's row-base load.
   assign w_buf_nxt  = w_at00 ? buf_sel : r_buf_active;
   assign w_base     = w_buf_nxt ? (BASE + ADDR_W'(FRAME_WORDS)) : BASE;
   assign buf_active = r_buf_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf_active <= 1'b0;
      end else begin
         r_buf_active <= w_buf_nxt;
      end
   end
`else
   assign w_base = BASE;
`endif

   vga_row_base_acc #(
      .ADDR_W  (ADDR_W),
      .RST_VAL (BASE),
      .STEP    (LINE_WORDS)
   ) u_row_base (
      .clk            (clk),
      .rst            (rst),
      .i_load         (w_at00),
      .i_load_val     (w_base),
      .i_inc          (w_inc),
      .o_row_base_nxt (w_rb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr        <= BASE;
         r_valid       <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_synced      <= 1'b0;
      end else begin
         if (w_act) begin
            r_addr <= w_rb + w_hoff;
         end
         r_valid       <= w_act && w_sync_ok;
         r_line_start  <= w_line0 && w_sync_ok;
         r_frame_start <= w_at00;
         if (w_at00) begin
            r_synced <= 1'b1;
         end
      end
   end

   assign addr        = r_addr;
   assign addr_valid  = r_valid;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pixel_addr_gen.sv
// Directed bench for vga_pixel_addr_gen: default geometry and 2x replication side by side.
module tb_vga_pixel_addr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  hc  = 10'd799;
   logic [9:0]  vc  = 10'd524;
   logic        buf_sel = 1'b0;

   logic [18:0] addr_a, addr_b;
   logic        valid_a, valid_b, ls_a, ls_b, fs_a, fs_b;
`ifdef VGA_DOUBLE_BUFFER_EN
   logic        buf_a, buf_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_pixel_addr_gen #(
      .H_ACTIVE(640), .V_ACTIVE(480), .ADDR_W(19), .SCALE_LOG2(0), .BASE_ADDR(0)
   ) dut_a (
      .clk(clk), .rst(rst), .hCounter(hc), .vCounter(vc),
      .addr(addr_a), .addr_valid(valid_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_DOUBLE_BUFFER_EN
      , .buf_sel(buf_sel), .buf_active(buf_a)
`endif
   );

   vga_pixel_addr_gen #(
      .H_ACTIVE(640), .V_ACTIVE(480), .ADDR_W(19), .SCALE_LOG2(1), .BASE_ADDR(0)
   ) dut_b (
      .clk(clk), .rst(rst), .hCounter(hc), .vCounter(vc),
      .addr(addr_b), .addr_valid(valid_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_DOUBLE_BUFFER_EN
      , .buf_sel(buf_sel), .buf_active(buf_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int ea, input int ev, input int el, input int ef);
      chk({tag, ".A.addr"},  {13'd0, addr_a},  ea);
      chk({tag, ".A.valid"}, {31'd0, valid_a}, ev);
      chk({tag, ".A.line"},  {31'd0, ls_a},    el);
      chk({tag, ".A.frame"}, {31'd0, fs_a},    ef);
   endtask

   task automatic chk_b(input string tag, input int ea, input int ev, input int el, input int ef);
      chk({tag, ".B.addr"},  {13'd0, addr_b},  ea);
      chk({tag, ".B.valid"}, {31'd0, valid_b}, ev);
      chk({tag, ".B.line"},  {31'd0, ls_b},    el);
      chk({tag, ".B.frame"}, {31'd0, fs_b},    ef);
   endtask

   task automatic step(input int h, input int v);
      hc = h[9:0];
      vc = v[9:0];
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_a("reset", 0, 0, 0, 0);
      chk_b("reset", 0, 0, 0, 0);

      // Reset coinciding with (0,0): reset wins, no sync.
      step(0, 0);
      chk_a("rst_at_00", 0, 0, 0, 0);
      chk_b("rst_at_00", 0, 0, 0, 0);
      rst = 1'b0;
      step(3, 0);
      chk_a("unsynced_3_0", 3, 0, 0, 0);
      chk_b("unsynced_3_0", 1, 0, 0, 0);
      step(0, 1);
      chk_a("unsynced_0_1", 640, 0, 0, 0);
      chk_b("unsynced_0_1", 0, 0, 0, 0);

      step(0, 0);
      chk_a("p0_0", 0, 1, 1, 1);
      chk_b("p0_0", 0, 1, 1, 1);
      step(639, 0);
      chk_a("p639_0", 639, 1, 0, 0);
      chk_b("p639_0", 319, 1, 0, 0);
      step(0, 1);
      chk_a("p0_1", 640, 1, 1, 0);
      chk_b("p0_1", 0, 1, 1, 0);
      step(5, 1);
      chk_a("p5_1", 645, 1, 0, 0);
      chk_b("p5_1", 2, 1, 0, 0);
      step(0, 2);
      chk_a("p0_2", 1280, 1, 1, 0);
      chk_b("p0_2", 320, 1, 1, 0);
      step(0, 3);
      chk_a("p0_3", 1920, 1, 1, 0);
      chk_b("p0_3", 320, 1, 1, 0);
      step(5, 3);
      chk_a("p5_3", 1925, 1, 0, 0);
      chk_b("p5_3", 322, 1, 0, 0);

      for (int v = 4; v < 480; v++) step(0, v);
      step(639, 479);
      chk_a("last_px", 307199, 1, 0, 0);
      chk_b("last_px", 76799, 1, 0, 0);

      step(640, 10);
      chk_a("h_edge", 307199, 0, 0, 0);
      chk_b("h_edge", 76799, 0, 0, 0);
      step(5, 480);
      chk_a("v_edge", 307199, 0, 0, 0);
      chk_b("v_edge", 76799, 0, 0, 0);
      step(0, 480);
      chk_a("v_edge_h0", 307199, 0, 0, 0);
      chk_b("v_edge_h0", 76799, 0, 0, 0);

      // Reset mid-frame: no valid output until the next (0,0).
      step(0, 0);
      chk_a("frame2", 0, 1, 1, 1);
      chk_b("frame2", 0, 1, 1, 1);
      rst = 1'b1;
      step(300, 200);
      chk_a("mid_rst", 0, 0, 0, 0);
      chk_b("mid_rst", 0, 0, 0, 0);
      rst = 1'b0;
      step(301, 200);
      chk_a("post_rst_a", 301, 0, 0, 0);
      chk_b("post_rst_a", 150, 0, 0, 0);
      step(0, 201);
      chk_a("post_rst_b", 640, 0, 0, 0);
      chk_b("post_rst_b", 0, 0, 0, 0);
      step(5, 479);
      chk_a("post_rst_c", 645, 0, 0, 0);
      chk_b("post_rst_c", 2, 0, 0, 0);
      step(0, 0);
      chk_a("resync", 0, 1, 1, 1);
      chk_b("resync", 0, 1, 1, 1);
      step(7, 0);
      chk_a("resync_7", 7, 1, 0, 0);
      chk_b("resync_7", 3, 1, 0, 0);

`ifdef VGA_DOUBLE_BUFFER_EN
      buf_sel = 1'b1;
      step(10, 0);
      chk_a("db_mid", 10, 1, 0, 0);
      chk_b("db_mid", 5, 1, 0, 0);
      chk("db_mid.A.buf", {31'd0, buf_a}, 0);
      chk("db_mid.B.buf", {31'd0, buf_b}, 0);
      step(0, 1);
      chk_a("db_line", 640, 1, 1, 0);
      chk_b("db_line", 0, 1, 1, 0);
      chk("db_line.A.buf", {31'd0, buf_a}, 0);
      step(0, 0);
      chk_a("db_swap", 307200, 1, 1, 1);
      chk_b("db_swap", 76800, 1, 1, 1);
      chk("db_swap.A.buf", {31'd0, buf_a}, 1);
      chk("db_swap.B.buf", {31'd0, buf_b}, 1);
      buf_sel = 1'b0;
      step(3, 0);
      chk_a("db_hold", 307203, 1, 0, 0);
      chk_b("db_hold", 76801, 1, 0, 0);
      chk("db_hold.A.buf", {31'd0, buf_a}, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
